fetch_block_iag: RTL and testbench
==================================

Name: fetch_block_iag

Overview:
Next-generation fetch instruction address generator. Produces one fetch block of FETCH_WIDTH instruction slots per cycle instead of a single PC. Each block, with its slot mask and prediction, is pushed into a fetch target queue (FTQ) that decouples prediction from the I-cache. Sits between the branch predictors (BTB, direction predictor, RA stack, all resolved externally into one pred_* bundle) and the fetch stage; decode and writeback redirects re-steer it.

Parameters:
ADDR, 32, address width
FETCH_WIDTH, 2, instruction slots per fetch block (power of 2, >=1)
INST_BYTES, 4, bytes per instruction slot (power of 2)
FTQ_DEPTH, 8, FTQ entries (power of 2, >=2)
RESET_PC, 0, first fetch address after reset
FTQ, $clog2(FTQ_DEPTH), derived pointer width
SLOT, max(1,$clog2(FETCH_WIDTH)), derived slot index width

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
gen_pc  out  ADDR  PC of the block currently being predicted, drives predictor lookup
pred_v  in  1  prediction for gen_pc valid this cycle
pred_taken  in  1  a slot in this block is predicted taken
pred_slot  in  SLOT  slot index of the taken branch
pred_target  in  ADDR  predicted target
dec_redirect_  in  1  decode redirect, active low
dec_redirect_pc  in  ADDR  decode redirect target
wb_flush_  in  1  writeback flush, active low
wb_flush_pc  in  ADDR  writeback flush target
ftq_e_  out  1  FTQ head valid, active low
ftq_pc  out  ADDR  head block PC
ftq_mask  out  FETCH_WIDTH  head valid slot mask
ftq_taken  out  1  head block ends in a predicted-taken branch
ftq_target  out  ADDR  head predicted target
ftq_pop_  in  1  consumer takes head, active low
ftq_count  out  FTQ+1  occupied entries
busy  out  1  FTQ full

Behaviour:
- Reset values: gen_pc=RESET_PC, ftq_e_=1, ftq_count=0, busy=0, ftq_pc/ftq_mask/ftq_taken/ftq_target=0, state=INIT, pointers=0.
- FSM states are INIT, RUN and REFILL.
  - INIT: first cycle after reset. No push. Goes to RUN.
  - RUN: push when pred_v=1 and (count<FTQ_DEPTH or pop in the same cycle).
  - REFILL: one-cycle bubble after any redirect so the predictor can look up the new gen_pc. No push. Goes to RUN.
- Redirect priority is wb_flush_ over dec_redirect_ over prediction.
  - On either redirect: FTQ cleared (count=0, pointers=0), gen_pc takes the redirect target, no push, next state REFILL.
  - A pop asserted in the same cycle is discarded.
  - A redirect in INIT or REFILL is also taken and restarts REFILL.
- Slot arithmetic:
  - offset = gen_pc[IB+SLOT-1:IB], where IB=$clog2(INST_BYTES).
  - mask[i]=1 iff i>=offset and (!eff_taken or i<=pred_slot).
  - eff_taken = pred_taken && pred_slot>=offset. A taken slot before the offset is ignored.
- Next PC on push: eff_taken ? pred_target : (gen_pc aligned down to FETCH_WIDTH*INST_BYTES) + FETCH_WIDTH*INST_BYTES. Wraps modulo 2^ADDR.
- Pushed entry = {gen_pc, mask, eff_taken, eff_taken?pred_target:0}.
- No push (full, or pred_v=0): gen_pc holds.
- Pop when ftq_e_=0 and ftq_pop_=0: head advances. Pop on empty is ignored.
- Push and pop in the same cycle: count unchanged. Allowed when full.
- Output latency: a pushed entry is visible at the head the next cycle.
- busy = (count==FTQ_DEPTH). ftq_e_ = (count==0).
- Pointers wrap modulo FTQ_DEPTH.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

Optional Feature:
FTQ_BYPASS_EN
- Defined: when the FTQ is empty and a push occurs, the entry appears combinationally on the head outputs in the same cycle with ftq_e_=0.
  - Same-cycle pop consumes it without storing; count stays 0.
  - No bypass while a redirect is active.
- Undefined: one-cycle push-to-head latency always.

Decomposition:
- Shared package: FtqEntry_t struct (pc, mask, taken, target), IagState_t enum (INIT, RUN, REFILL), FETCH_BYTES constant.
- One natural sub-module, ftq_fifo: parametrised circular buffer of FtqEntry_t with push/pop/clear/count. The IAG holds the FSM and PC arithmetic.

Test Plan:
- Reset, no prediction (pred_v=1, pred_taken=0), FETCH_WIDTH=2, never pop: pushes 0x0, 0x8, 0x10, ..., mask 2'b11. busy=1 after 8 pushes; gen_pc holds at 0x40.
- gen_pc=0x104, pred_taken=1, pred_slot=1, target=0x200: entry mask 2'b10, ftq_taken=1; next gen_pc=0x200.
- gen_pc=0x104, pred_taken=1, pred_slot=0: prediction ignored, mask 2'b10, next gen_pc=0x108.
- FTQ holds 5 entries; wb_flush_=0 and dec_redirect_=0 together, wb_flush_pc=0x80: count=0 next cycle, gen_pc=0x80, one REFILL bubble, first push at 0x80.
- Full FTQ with simultaneous push and pop: count stays 8, FIFO order preserved over 20 cycles of random pops.
- FTQ_BYPASS_EN, empty FTQ, push 0x300 with ftq_pop_=0 in the same cycle: ftq_pc=0x300 valid that cycle, count stays 0.

Source files
------------

// File: rtl/fetch_block_iag_pkg.sv
// Shared types and default geometry for the fetch block address generator.
// The optional head bypass is enabled by defining FTQ_BYPASS_EN.
package fetch_block_iag_pkg;
   localparam int ADDR_W = 32;
   localparam int FW_W = 2;
   localparam int INST_B = 4;
   localparam int FETCH_BYTES = FW_W * INST_B;

   typedef enum logic [1:0] {INIT, RUN, REFILL} IagState_t;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [FW_W-1:0]   mask;
      logic              taken;
      logic [ADDR_W-1:0] target;
   } FtqEntry_t;
endpackage

// File: rtl/fetch_block_iag_if.sv
// Predictor, redirect and FTQ head bundle of the fetch block generator.
// master = the generator, slave = predictor/fetch side.
interface fetch_block_iag_if #(
   parameter int ADDR = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int FTQ_DEPTH = 8
);
   localparam int SLOT = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int FTQ = $clog2(FTQ_DEPTH);

   logic [ADDR-1:0]        gen_pc;
   logic                   pred_v;
   logic                   pred_taken;
   logic [SLOT-1:0]        pred_slot;
   logic [ADDR-1:0]        pred_target;
   logic                   dec_redirect_;
   logic [ADDR-1:0]        dec_redirect_pc;
   logic                   wb_flush_;
   logic [ADDR-1:0]        wb_flush_pc;
   logic                   ftq_e_;
   logic [ADDR-1:0]        ftq_pc;
   logic [FETCH_WIDTH-1:0] ftq_mask;
   logic                   ftq_taken;
   logic [ADDR-1:0]        ftq_target;
   logic                   ftq_pop_;
   logic [FTQ:0]           ftq_count;
   logic                   busy;

   modport master (
      output gen_pc, ftq_e_, ftq_pc, ftq_mask, ftq_taken,
             ftq_target, ftq_count, busy,
      input  pred_v, pred_taken, pred_slot, pred_target,
             dec_redirect_, dec_redirect_pc, wb_flush_,
             wb_flush_pc, ftq_pop_
   );

   modport slave (
      input  gen_pc, ftq_e_, ftq_pc, ftq_mask, ftq_taken,
             ftq_target, ftq_count, busy,
      output pred_v, pred_taken, pred_slot, pred_target,
             dec_redirect_, dec_redirect_pc, wb_flush_,
             wb_flush_pc, ftq_pop_
   );
endinterface

// File: rtl/fetch_block_iag_ftq_fifo.sv
// Fetch target queue: circular buffer of fetch block entries.
// Clear wins over push/pop; head reads zero when empty.
module fetch_block_iag_ftq_fifo
   import fetch_block_iag_pkg::*;
#(
   parameter type T = FtqEntry_t,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset_,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  T                         din,
   output T                         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [PW-1:0]  wr;
   logic [PW-1:0]  rd;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else if (clear) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
      end else begin
         if (push) wr <= wr + PW'(1);
         if (pop)  rd <= rd + PW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr] <= din;
   end

   assign empty = (count == '0);
   assign full  = (count == (PW+1)'(DEPTH));
   assign dout  = empty ? T'('0) : mem[rd];
endmodule

// File: rtl/fetch_block_iag.sv
// Fetch block instruction address generator feeding a fetch target queue.
// Optional same-cycle head bypass when the queue is empty: FTQ_BYPASS_EN.
module fetch_block_iag
   import fetch_block_iag_pkg::*;
#(
   parameter int ADDR = ADDR_W,
   parameter int FETCH_WIDTH = FW_W,
   parameter int INST_BYTES = INST_B,
   parameter int FTQ_DEPTH = 8,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic reset_,
   fetch_block_iag_if.master bus
);
   localparam int SLOT = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
   localparam int FTQ = $clog2(FTQ_DEPTH);
   localparam int IB = $clog2(INST_BYTES);
   localparam logic [ADDR-1:0] BLK = ADDR'(FETCH_WIDTH * INST_BYTES);
   localparam logic [ADDR-1:0] BLK_MASK = ~(BLK - ADDR'(1));

   typedef struct packed {
      logic [ADDR-1:0]        pc;
      logic [FETCH_WIDTH-1:0] mask;
      logic                   taken;
      logic [ADDR-1:0]        target;
   } entry_t;

   IagState_t              state;
   IagState_t              state_nx;
   logic [ADDR-1:0]        pc_nx;
   logic [ADDR-1:0]        seq_pc;
   logic [ADDR-1:0]        redir_pc;
   logic [SLOT-1:0]        offset;
   logic [FETCH_WIDTH-1:0] mask;
   logic                   redirect;
   logic                   eff_taken;
   logic                   pop_ask;
   logic                   push_ok;
   logic                   push;
   logic                   pop;
   logic                   bypass;
   logic                   fifo_empty;
   logic                   fifo_full;
   logic [FTQ:0]           fifo_count;
   entry_t                 new_e;
   entry_t                 fifo_head;
   entry_t                 head;

   assign redirect = !bus.wb_flush_ || !bus.dec_redirect_;
   assign redir_pc = !bus.wb_flush_ ? bus.wb_flush_pc
                                    : bus.dec_redirect_pc;

   if (FETCH_WIDTH > 1) begin : g_off
      assign offset = bus.gen_pc[IB +: SLOT];
   end else begin : g_off0
      assign offset = '0;
   end

   // A taken slot sitting before the entry offset cannot end this block
   assign eff_taken = bus.pred_taken && (bus.pred_slot >= offset);
   assign seq_pc = (bus.gen_pc & BLK_MASK) + BLK;

   always_comb begin
      mask = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         mask[i] = (SLOT'(i) >= offset) &&
                   (!eff_taken || SLOT'(i) <= bus.pred_slot);
      end
   end

   always_comb begin
      new_e.pc     = bus.gen_pc;
      new_e.mask   = mask;
      new_e.taken  = eff_taken;
      new_e.target = eff_taken ? bus.pred_target : '0;
   end

   // Full queue still accepts when the head leaves this cycle
   assign pop_ask = !bus.ftq_pop_;
   assign push_ok = (state == RUN) && !redirect && bus.pred_v &&
                    (!fifo_full || pop_ask);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= INIT;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         INIT:    state_nx = RUN;
         RUN:     state_nx = RUN;
         REFILL:  state_nx = RUN;
         default: state_nx = INIT;
      endcase
      if (redirect) state_nx = REFILL;
   end

   always_comb begin
      push  = 1'b0;
      pc_nx = bus.gen_pc;
      unique case (1'b1)
         redirect: pc_nx = redir_pc;
         push_ok: begin
            push  = 1'b1;
            pc_nx = eff_taken ? bus.pred_target : seq_pc;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) bus.gen_pc <= RESET_PC;
      else         bus.gen_pc <= pc_nx;
   end

`ifdef FTQ_BYPASS_EN
   assign bypass = push && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign head = bypass ? new_e : fifo_head;
   assign bus.ftq_e_ = fifo_empty && !bypass;
   assign pop = pop_ask && !bus.ftq_e_ && !redirect;

   fetch_block_iag_ftq_fifo #(
      .T     (entry_t),
      .DEPTH (FTQ_DEPTH)
   ) u_ftq (
      .clk    (clk),
      .reset_ (reset_),
      .push   (push && !(bypass && pop)),
      .pop    (pop && !bypass),
      .clear  (redirect),
      .din    (new_e),
      .dout   (fifo_head),
      .count  (fifo_count),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   assign bus.ftq_pc     = head.pc;
   assign bus.ftq_mask   = head.mask;
   assign bus.ftq_taken  = head.taken;
   assign bus.ftq_target = head.target;
   assign bus.ftq_count  = fifo_count;
   assign bus.busy       = fifo_full;
endmodule

// File: tb/tb_fetch_block_iag.sv
// Scoreboard bench for fetch_block_iag (FETCH_WIDTH=2, FTQ_DEPTH=8).
// Build with FTQ_BYPASS_EN to exercise the bypass variant.
module tb_fetch_block_iag;
   typedef logic [66:0] ent_t;

   logic clk = 1'b0;
   logic reset_;
   int   n_checks = 0;
   int   n_fail = 0;
   ent_t exp_q[$];
   ent_t head;
   ent_t exp_e;

   always #5 clk = ~clk;

   fetch_block_iag_if #(.ADDR(32), .FETCH_WIDTH(2), .FTQ_DEPTH(8)) bus();

   fetch_block_iag #(
      .ADDR(32), .FETCH_WIDTH(2), .INST_BYTES(4),
      .FTQ_DEPTH(8), .RESET_PC(32'h0)
   ) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus.master)
   );

   assign head = {bus.ftq_pc, bus.ftq_mask, bus.ftq_taken, bus.ftq_target};

   function automatic ent_t mk(input logic [31:0] pc, input logic [1:0] m,
                               input logic t, input logic [31:0] tg);
      return {pc, m, t, tg};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pred_v = 1'b0;
      bus.pred_taken = 1'b0;
      bus.pred_slot = 1'b0;
      bus.pred_target = '0;
      bus.dec_redirect_ = 1'b1;
      bus.dec_redirect_pc = '0;
      bus.wb_flush_ = 1'b1;
      bus.wb_flush_pc = '0;
      bus.ftq_pop_ = 1'b1;
   endtask

   // Flush to pc and sit through the refill bubble; queue ends empty
   task automatic steer(input logic [31:0] pc);
      idle();
      bus.wb_flush_ = 1'b0;
      bus.wb_flush_pc = pc;
      tick();
      bus.wb_flush_ = 1'b1;
      tick();
      exp_q.delete();
   endtask

   task automatic test_reset();
      idle();
      reset_ = 1'b1;
      #1 reset_ = 1'b0;
      #2;
      n_checks++;
      if (bus.gen_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_gen_pc: got %h want 0", bus.gen_pc);
      end
      n_checks++;
      if ({bus.ftq_e_, bus.busy, bus.ftq_count} !== {1'b1, 1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL reset_flags: e_=%b busy=%b count=%0d want 1 0 0",
                  bus.ftq_e_, bus.busy, bus.ftq_count);
      end
      n_checks++;
      if (head !== '0) begin
         n_fail++;
         $display("FAIL reset_head: got %h want 0", head);
      end
   endtask

   task automatic test_sequential();
      bus.pred_v = 1'b1;
      tick();
      reset_ = 1'b1;
      tick();
      n_checks++;
      if (bus.ftq_count !== 4'd0 || bus.gen_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL init_no_push: count=%0d pc=%h want 0 0",
                  bus.ftq_count, bus.gen_pc);
      end
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(32'(i * 8), 2'b11, 1'b0, 32'h0));
         tick();
         n_checks++;
         if (bus.ftq_count !== 4'(i + 1)) begin
            n_fail++;
            $display("FAIL seq_count: got %0d want %0d", bus.ftq_count, i + 1);
         end
      end
      tick();
      tick();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.ftq_count !== 4'd8) begin
         n_fail++;
         $display("FAIL seq_full: busy=%b count=%0d want 1 8",
                  bus.busy, bus.ftq_count);
      end
      n_checks++;
      if (bus.gen_pc !== 32'h40) begin
         n_fail++;
         $display("FAIL seq_hold_pc: got %h want 40", bus.gen_pc);
      end
      bus.pred_v = 1'b0;
      bus.ftq_pop_ = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_e = exp_q.pop_front();
         n_checks++;
         if (bus.ftq_e_ !== 1'b0 || head !== exp_e) begin
            n_fail++;
            $display("FAIL seq_drain: e_=%b head=%h want %h",
                     bus.ftq_e_, head, exp_e);
         end
         tick();
      end
      n_checks++;
      if (bus.ftq_e_ !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_empty: e_=%b busy=%b want 1 0",
                  bus.ftq_e_, bus.busy);
      end
      idle();
   endtask

   task automatic test_taken(input logic [1:0] slot, input logic [31:0] pc_next,
                             input logic t);
      steer(32'h104);
      bus.pred_v = 1'b1;
      bus.pred_taken = 1'b1;
      bus.pred_slot = slot[0];
      bus.pred_target = 32'h200;
      exp_q.push_back(mk(32'h104, 2'b10, t, t ? 32'h200 : 32'h0));
      tick();
      idle();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (head !== exp_e || bus.ftq_count !== 4'd1) begin
         n_fail++;
         $display("FAIL taken_entry slot%0d: head=%h count=%0d want %h 1",
                  slot, head, bus.ftq_count, exp_e);
      end
      n_checks++;
      if (bus.gen_pc !== pc_next) begin
         n_fail++;
         $display("FAIL taken_next slot%0d: got %h want %h",
                  slot, bus.gen_pc, pc_next);
      end
   endtask

   task automatic test_redirect();
      steer(32'h1000);
      bus.pred_v = 1'b1;
      repeat (5) tick();
      bus.pred_v = 1'b0;
      n_checks++;
      if (bus.ftq_count !== 4'd5) begin
         n_fail++;
         $display("FAIL redir_fill: got %0d want 5", bus.ftq_count);
      end
      bus.pred_v = 1'b1;
      bus.wb_flush_ = 1'b0;
      bus.wb_flush_pc = 32'h80;
      bus.dec_redirect_ = 1'b0;
      bus.dec_redirect_pc = 32'h900;
      bus.ftq_pop_ = 1'b0;
      tick();
      n_checks++;
      if (bus.ftq_count !== 4'd0 || bus.ftq_e_ !== 1'b1 ||
          bus.gen_pc !== 32'h80) begin
         n_fail++;
         $display("FAIL redir_prio: count=%0d e_=%b pc=%h want 0 1 80",
                  bus.ftq_count, bus.ftq_e_, bus.gen_pc);
      end
      bus.wb_flush_ = 1'b1;
      bus.dec_redirect_ = 1'b1;
      bus.ftq_pop_ = 1'b1;
      tick();
      n_checks++;
      if (bus.ftq_count !== 4'd0 || bus.gen_pc !== 32'h80) begin
         n_fail++;
         $display("FAIL redir_bubble: count=%0d pc=%h want 0 80",
                  bus.ftq_count, bus.gen_pc);
      end
      exp_q.push_back(mk(32'h80, 2'b11, 1'b0, 32'h0));
      tick();
      exp_e = exp_q.pop_front();
      n_checks++;
      if (bus.ftq_count !== 4'd1 || head !== exp_e ||
          bus.gen_pc !== 32'h88) begin
         n_fail++;
         $display("FAIL redir_first: count=%0d head=%h pc=%h want 1 %h 88",
                  bus.ftq_count, head, bus.gen_pc, exp_e);
      end
      idle();
      bus.dec_redirect_ = 1'b0;
      bus.dec_redirect_pc = 32'h500;
      tick();
      idle();
      n_checks++;
      if (bus.gen_pc !== 32'h500 || bus.ftq_count !== 4'd0) begin
         n_fail++;
         $display("FAIL dec_redirect: pc=%h count=%0d want 500 0",
                  bus.gen_pc, bus.ftq_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] model_pc;
      logic        p;
      steer(32'h2000);
      model_pc = 32'h2000;
      bus.pred_v = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(model_pc, 2'b11, 1'b0, 32'h0));
         model_pc += 32'h8;
         tick();
      end
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_full: busy=%b want 1", bus.busy);
      end
      for (int c = 0; c < 20; c++) begin
         p = 1'($urandom_range(0, 1));
         bus.ftq_pop_ = !p;
         n_checks++;
         if (head !== exp_q[0]) begin
            n_fail++;
            $display("FAIL b2b_head cyc%0d: got %h want %h", c, head, exp_q[0]);
         end
         if (p) begin
            void'(exp_q.pop_front());
            exp_q.push_back(mk(model_pc, 2'b11, 1'b0, 32'h0));
            model_pc += 32'h8;
         end
         tick();
         n_checks++;
         if (bus.ftq_count !== 4'd8 || bus.gen_pc !== model_pc) begin
            n_fail++;
            $display("FAIL b2b_state cyc%0d: count=%0d pc=%h want 8 %h",
                     c, bus.ftq_count, bus.gen_pc, model_pc);
         end
      end
      idle();
   endtask

   task automatic test_push_latency();
      steer(32'h300);
      bus.pred_v = 1'b1;
      bus.ftq_pop_ = 1'b0;
      exp_e = mk(32'h300, 2'b11, 1'b0, 32'h0);
      #1;
`ifdef FTQ_BYPASS_EN
      n_checks++;
      if (bus.ftq_e_ !== 1'b0 || head !== exp_e) begin
         n_fail++;
         $display("FAIL bypass_head: e_=%b head=%h want 0 %h",
                  bus.ftq_e_, head, exp_e);
      end
      tick();
      idle();
      n_checks++;
      if (bus.ftq_count !== 4'd0 || bus.ftq_e_ !== 1'b1 ||
          bus.gen_pc !== 32'h308) begin
         n_fail++;
         $display("FAIL bypass_consumed: count=%0d e_=%b pc=%h want 0 1 308",
                  bus.ftq_count, bus.ftq_e_, bus.gen_pc);
      end
`else
      n_checks++;
      if (bus.ftq_e_ !== 1'b1) begin
         n_fail++;
         $display("FAIL latency_empty: e_=%b want 1", bus.ftq_e_);
      end
      tick();
      idle();
      n_checks++;
      if (bus.ftq_count !== 4'd1 || head !== exp_e ||
          bus.gen_pc !== 32'h308) begin
         n_fail++;
         $display("FAIL latency_head: count=%0d head=%h pc=%h want 1 %h 308",
                  bus.ftq_count, head, bus.gen_pc, exp_e);
      end
`endif
   endtask

   task automatic test_async_reset();
      steer(32'h700);
      bus.pred_v = 1'b1;
      repeat (3) tick();
      #2 reset_ = 1'b0;
      #1;
      n_checks++;
      if (bus.gen_pc !== 32'h0 || bus.ftq_count !== 4'd0 ||
          bus.ftq_e_ !== 1'b1 || head !== '0) begin
         n_fail++;
         $display("FAIL async_reset: pc=%h count=%0d e_=%b head=%h",
                  bus.gen_pc, bus.ftq_count, bus.ftq_e_, head);
      end
      idle();
      tick();
      reset_ = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_taken(2'd1, 32'h200, 1'b1);
      test_taken(2'd0, 32'h108, 1'b0);
      test_redirect();
      test_back_to_back();
      test_push_latency();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
